// File: rtl/lane_deskew_merger_if.sv
`default_nettype none
// ============================================================================
// lane_deskew_merger_if : lane inputs and OS / merged outputs of the merger.
// Optional macro SKEW_REPORT_EN adds skew_val.                 Rev 1.0
// ============================================================================
interface lane_deskew_merger_if;
   logic       enable_r;
   logic       data_os;
   logic [7:0] lane_0_rx_in;
   logic       lane_0_vld;
   logic [7:0] lane_1_rx_in;
   logic       lane_1_vld;
   logic [7:0] lane_0_os_out;
   logic [7:0] lane_1_os_out;
   logic       os_vld;
   logic [7:0] merged_out;
   logic       merged_vld;
   logic       aligned;
   logic       skew_err;
   logic       ovf_err;
`ifdef SKEW_REPORT_EN
   logic [3:0] skew_val;
`endif

   modport slave (
      input  enable_r, data_os, lane_0_rx_in, lane_0_vld, lane_1_rx_in, lane_1_vld,
`ifdef SKEW_REPORT_EN
      output skew_val,
`endif
      output lane_0_os_out, lane_1_os_out, os_vld, merged_out, merged_vld,
      output aligned, skew_err, ovf_err
   );

   modport master (
      output enable_r, data_os, lane_0_rx_in, lane_0_vld, lane_1_rx_in, lane_1_vld,
`ifdef SKEW_REPORT_EN
      input  skew_val,
`endif
      input  lane_0_os_out, lane_1_os_out, os_vld, merged_out, merged_vld,
      input  aligned, skew_err, ovf_err
   );
endinterface
`default_nettype wire

// File: rtl/lane_deskew_merger.sv
`default_nettype none
// ============================================================================
// lane_deskew_merger : two-lane marker deskew FIFOs, OS pair / block re-merge.
// Optional macro SKEW_REPORT_EN adds the skew_val report.      Rev 1.0
// ============================================================================
module lane_deskew_merger #(
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] ALIGN_SYM  = 8'hBC,
   parameter int         BLOCK_LEN  = 4,
   parameter int         MAX_SKEW   = 6
) (
   input  wire logic            clk,
   input  wire logic            rst,
   lane_deskew_merger_if.slave  bus
);
   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_BW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam int c_SW = $clog2(MAX_SKEW + 2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_OS    = 2'd2,
      ST_DATA  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [c_AW:0]   wp0_q, wp0_d, rp0_q, rp0_d, wp1_q, wp1_d, rp1_q, rp1_d;
   logic            mk0_q, mk0_d, mk1_q, mk1_d;
   logic [c_SW-1:0] cnt_q, cnt_d;
   logic            sel_q, sel_d;
   logic [c_BW-1:0] blk_q, blk_d;
   logic [7:0]      os0_q, os0_d, os1_q, os1_d, mrg_q, mrg_d;
   logic            os_vld_q, os_vld_d, mrg_vld_q, mrg_vld_d;
   logic            aligned_q, aligned_d, skew_err_q, skew_err_d, ovf_q, ovf_d;
`ifdef SKEW_REPORT_EN
   logic [3:0]      skew_val_q, skew_val_d;
`endif
   logic [7:0]      mem0_q [FIFO_DEPTH];
   logic [7:0]      mem1_q [FIFO_DEPTH];

   logic            w_empty0, w_empty1, w_full0, w_full1, w_active;
   logic            w_push0, w_push1, w_pop0, w_pop1, w_wr0, w_wr1, w_ovf, w_m0, w_m1;
   logic [c_SW-1:0] w_cnt_inc;
   logic [7:0]      w_rd0, w_rd1;

   assign w_empty0  = (wp0_q == rp0_q);
   assign w_empty1  = (wp1_q == rp1_q);
   assign w_full0   = (wp0_q[c_AW] != rp0_q[c_AW]) && (wp0_q[c_AW-1:0] == rp0_q[c_AW-1:0]);
   assign w_full1   = (wp1_q[c_AW] != rp1_q[c_AW]) && (wp1_q[c_AW-1:0] == rp1_q[c_AW-1:0]);
   assign w_active  = (state_q != ST_IDLE);
   assign w_push0   = w_active && mk0_q && bus.lane_0_vld;
   assign w_push1   = w_active && mk1_q && bus.lane_1_vld;
   assign w_pop0    = ((state_q == ST_OS) && !w_empty0 && !w_empty1) ||
                      ((state_q == ST_DATA) && !sel_q && !w_empty0);
   assign w_pop1    = ((state_q == ST_OS) && !w_empty0 && !w_empty1) ||
                      ((state_q == ST_DATA) && sel_q && !w_empty1);
   // A full FIFO still accepts a byte when it is popped in the same cycle.
   assign w_wr0     = w_push0 && (!w_full0 || w_pop0);
   assign w_wr1     = w_push1 && (!w_full1 || w_pop1);
   assign w_ovf     = (w_push0 && !w_wr0) || (w_push1 && !w_wr1);
   assign w_m0      = (state_q == ST_ALIGN) && !mk0_q && bus.lane_0_vld && (bus.lane_0_rx_in == ALIGN_SYM);
   assign w_m1      = (state_q == ST_ALIGN) && !mk1_q && bus.lane_1_vld && (bus.lane_1_rx_in == ALIGN_SYM);
   assign w_rd0     = mem0_q[rp0_q[c_AW-1:0]];
   assign w_rd1     = mem1_q[rp1_q[c_AW-1:0]];
   assign w_cnt_inc = cnt_q + c_SW'(1);

   always_ff @(posedge clk) begin
      if (w_wr0) mem0_q[wp0_q[c_AW-1:0]] <= bus.lane_0_rx_in;
      if (w_wr1) mem1_q[wp1_q[c_AW-1:0]] <= bus.lane_1_rx_in;
   end

   always_comb begin
      state_d    = state_q;
      wp0_d      = wp0_q + (c_AW+1)'(w_wr0);
      rp0_d      = rp0_q + (c_AW+1)'(w_pop0);
      wp1_d      = wp1_q + (c_AW+1)'(w_wr1);
      rp1_d      = rp1_q + (c_AW+1)'(w_pop1);
      mk0_d      = mk0_q;
      mk1_d      = mk1_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      blk_d      = blk_q;
      os0_d      = os0_q;
      os1_d      = os1_q;
      mrg_d      = mrg_q;
      os_vld_d   = 1'b0;
      mrg_vld_d  = 1'b0;
      aligned_d  = aligned_q;
      skew_err_d = 1'b0;
      ovf_d      = ovf_q;
`ifdef SKEW_REPORT_EN
      skew_val_d = skew_val_q;
`endif
      case (state_q)
         ST_IDLE: state_d = ST_ALIGN;
         ST_ALIGN: begin
            mk0_d = mk0_q | w_m0;
            mk1_d = mk1_q | w_m1;
            if (mk0_q ^ mk1_q) begin
               if (cnt_q == c_SW'(MAX_SKEW)) begin
                  skew_err_d = 1'b1;
                  mk0_d      = 1'b0;
                  mk1_d      = 1'b0;
                  cnt_d      = '0;
                  wp0_d      = '0;
                  rp0_d      = '0;
                  wp1_d      = '0;
                  rp1_d      = '0;
               end else if (w_m0 || w_m1) begin
                  aligned_d  = 1'b1;
                  cnt_d      = '0;
                  state_d    = bus.data_os ? ST_DATA : ST_OS;
`ifdef SKEW_REPORT_EN
                  skew_val_d = {mk1_q, 3'(w_cnt_inc)};
`endif
               end else begin
                  cnt_d = w_cnt_inc;
               end
            end else if (w_m0 && w_m1) begin
               aligned_d  = 1'b1;
               state_d    = bus.data_os ? ST_DATA : ST_OS;
`ifdef SKEW_REPORT_EN
               skew_val_d = 4'd0;
`endif
            end
         end
         ST_OS: begin
            if (w_pop0) begin
               os0_d    = w_rd0;
               os1_d    = w_rd1;
               os_vld_d = 1'b1;
            end
            if (bus.data_os) begin
               state_d = ST_DATA;
               blk_d   = '0;
               sel_d   = 1'b0;
            end
         end
         ST_DATA: begin
            if (w_pop0 || w_pop1) begin
               mrg_d     = sel_q ? w_rd1 : w_rd0;
               mrg_vld_d = 1'b1;
               if (blk_q == c_BW'(BLOCK_LEN - 1)) begin
                  blk_d = '0;
                  sel_d = ~sel_q;
               end else begin
                  blk_d = blk_q + c_BW'(1);
               end
            end
            if (!bus.data_os) begin
               state_d = ST_OS;
               blk_d   = '0;
               sel_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Overflow drops the offending byte and forces a fresh alignment.
      if (w_ovf) begin
         ovf_d     = 1'b1;
         aligned_d = 1'b0;
         state_d   = ST_ALIGN;
         mk0_d     = 1'b0;
         mk1_d     = 1'b0;
         cnt_d     = '0;
         blk_d     = '0;
         sel_d     = 1'b0;
         wp0_d     = '0;
         rp0_d     = '0;
         wp1_d     = '0;
         rp1_d     = '0;
         os0_d     = '0;
         os1_d     = '0;
         mrg_d     = '0;
         os_vld_d  = 1'b0;
         mrg_vld_d = 1'b0;
      end

      if (!bus.enable_r) begin
         state_d    = ST_IDLE;
         wp0_d      = '0;
         rp0_d      = '0;
         wp1_d      = '0;
         rp1_d      = '0;
         mk0_d      = 1'b0;
         mk1_d      = 1'b0;
         cnt_d      = '0;
         sel_d      = 1'b0;
         blk_d      = '0;
         os0_d      = '0;
         os1_d      = '0;
         mrg_d      = '0;
         os_vld_d   = 1'b0;
         mrg_vld_d  = 1'b0;
         aligned_d  = 1'b0;
         skew_err_d = 1'b0;
         ovf_d      = 1'b0;
`ifdef SKEW_REPORT_EN
         skew_val_d = 4'd0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wp0_q      <= '0;
         rp0_q      <= '0;
         wp1_q      <= '0;
         rp1_q      <= '0;
         mk0_q      <= 1'b0;
         mk1_q      <= 1'b0;
         cnt_q      <= '0;
         sel_q      <= 1'b0;
         blk_q      <= '0;
         os0_q      <= '0;
         os1_q      <= '0;
         mrg_q      <= '0;
         os_vld_q   <= 1'b0;
         mrg_vld_q  <= 1'b0;
         aligned_q  <= 1'b0;
         skew_err_q <= 1'b0;
         ovf_q      <= 1'b0;
`ifdef SKEW_REPORT_EN
         skew_val_q <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         wp0_q      <= wp0_d;
         rp0_q      <= rp0_d;
         wp1_q      <= wp1_d;
         rp1_q      <= rp1_d;
         mk0_q      <= mk0_d;
         mk1_q      <= mk1_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         blk_q      <= blk_d;
         os0_q      <= os0_d;
         os1_q      <= os1_d;
         mrg_q      <= mrg_d;
         os_vld_q   <= os_vld_d;
         mrg_vld_q  <= mrg_vld_d;
         aligned_q  <= aligned_d;
         skew_err_q <= skew_err_d;
         ovf_q      <= ovf_d;
`ifdef SKEW_REPORT_EN
         skew_val_q <= skew_val_d;
`endif
      end
   end

   assign bus.lane_0_os_out = os0_q;
   assign bus.lane_1_os_out = os1_q;
   assign bus.os_vld        = os_vld_q;
   assign bus.merged_out    = mrg_q;
   assign bus.merged_vld    = mrg_vld_q;
   assign bus.aligned       = aligned_q;
   assign bus.skew_err      = skew_err_q;
   assign bus.ovf_err       = ovf_q;
`ifdef SKEW_REPORT_EN
   assign bus.skew_val      = skew_val_q;
`endif
endmodule
`default_nettype wire

// File: doc/lane_deskew_merger.md
Name: lane_deskew_merger

Overview:
- Receive-side counterpart of the two-lane transmit distributer; sits between the per-lane receive datapath and the receive data bus.
- Aligns lane 0 and lane 1 on a per-lane alignment symbol and buffers each lane in a small FIFO to absorb inter-lane skew.
- Ordered-set mode: emits byte pairs, both lanes in lockstep.
- Transport-data mode: re-merges the stream by taking BLOCK_LEN bytes alternately from lane 0 and lane 1 onto a single byte bus.

Parameters:
- FIFO_DEPTH, 8, entries per lane FIFO (power of 2, >= MAX_SKEW+2).
- ALIGN_SYM, 8'hBC, alignment marker byte.
- BLOCK_LEN, 4, bytes taken from one lane before switching lanes in data mode.
- MAX_SKEW, 6, max cycles between the two lanes' markers before declaring a skew error.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- enable_r  input  1  receive enable; low = synchronous clear.
- data_os  input  1  0 = ordered sets, 1 = transport data.
- lane_0_rx_in  input  8  lane 0 byte.
- lane_0_vld  input  1  lane 0 byte valid.
- lane_1_rx_in  input  8  lane 1 byte.
- lane_1_vld  input  1  lane 1 byte valid.
- lane_0_os_out  output  8  ordered-set byte, lane 0.
- lane_1_os_out  output  8  ordered-set byte, lane 1.
- os_vld  output  1  OS byte pair valid.
- merged_out  output  8  merged transport byte.
- merged_vld  output  1  merged byte valid.
- aligned  output  1  lanes deskewed.
- skew_err  output  1  one-cycle pulse, skew limit exceeded.
- ovf_err  output  1  sticky, FIFO overflow.

Behaviour:
- Reset (rst high, async): state IDLE, both FIFOs empty, all counters 0, every output 0.
- enable_r low: same clear as reset, applied on the clock edge.
- States are IDLE, ALIGN, OS, DATA.
- IDLE -> ALIGN on the first cycle with enable_r=1.
- ALIGN, marker handling:
  - Per lane, valid bytes are dropped until a byte equal to ALIGN_SYM arrives.
  - The marker itself is not stored; subsequent valid bytes on that lane are written to its FIFO.
- ALIGN, skew counting:
  - The first lane to see its marker starts skew_cnt, which increments each cycle until the other lane's marker arrives.
  - Both markers in the same cycle = skew 0.
  - If skew_cnt reaches MAX_SKEW+1: skew_err pulses 1 cycle, both FIFOs flush, marker flags clear, state stays ALIGN.
- ALIGN exit: when both markers are seen, aligned=1 the next cycle; next state is OS if data_os=0, DATA if data_os=1.
- OS state: when both FIFOs are non-empty, pop one entry from each in the same cycle. Register the popped bytes to lane_0_os_out/lane_1_os_out with os_vld=1. Otherwise os_vld=0 and outputs hold.
- DATA state:
  - lane_sel starts at 0 and blk_cnt at 0.
  - If the lane_sel FIFO is non-empty: pop it, merged_out <= byte, merged_vld=1, blk_cnt++.
  - When blk_cnt wraps at BLOCK_LEN-1 -> 0, lane_sel toggles.
  - If the selected FIFO is empty: merged_vld=0; blk_cnt and lane_sel hold (stall, no skipping to the other lane).
- Mode switches (while aligned):
  - data_os 1->0: go to OS next cycle; blk_cnt=0, lane_sel=0; FIFO contents kept.
  - data_os 0->1: go to DATA with blk_cnt=0, lane_sel=0.
- Latency: byte written at edge N, earliest pop at N+1, output valid after edge N+1 (2-cycle input-to-output minimum).
- FIFO boundaries:
  - Push and pop in the same cycle on a full FIFO is legal and not an overflow.
  - A pop on empty never occurs (it is gated).
- Overflow: a push to a full FIFO without a simultaneous pop drops the byte and causes all of the following:
  - ovf_err=1, sticky until rst or enable_r low.
  - aligned=0.
  - Both FIFOs flush and state returns to ALIGN.
- Outputs in IDLE/ALIGN: os_vld=0, merged_vld=0, data outputs 0.
- Pointer arithmetic: log2(FIFO_DEPTH)+1-bit pointers; the extra bit distinguishes full from empty; wrap-around is natural.

Optional Feature:
- Macro SKEW_REPORT_EN.
- Defined: adds output skew_val [3:0], registered when alignment completes.
  - Bit 3 = lead lane (0 = lane 0 marker first); bits 2:0 = skew_cnt.
  - Holds until the next alignment; 0 on reset or enable_r low.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Markers on both lanes in the same cycle, data_os=0, lane0 bytes 0x11,0x22, lane1 bytes 0x33,0x44 -> aligned=1; os pairs (0x11,0x33) then (0x22,0x44) with os_vld=1; first pair 2 cycles after first write.
- Lane 1 marker 3 cycles after lane 0, data_os=1, lane0 0x00..0x07, lane1 0x10..0x17 -> merged_out 00,01,02,03,10,11,12,13,04,05,06,07,14,...; SKEW_REPORT_EN build gives skew_val=4'b0011.
- Lane 1 marker never arrives -> skew_err 1-cycle pulse 7 cycles after the lane 0 marker; FIFOs empty; aligned=0; state ALIGN.
- Data mode with lane 1 valid gapped after 4 lane 0 bytes -> merged_vld=0 while stalled; no lane 0 byte emitted out of order; resumes with lane 1 byte.
- Lane 0 pushes 9 bytes with no pops (lane 1 idle, DATA, lane_sel=1) -> ovf_err=1 sticky, aligned=0; enable_r low for 1 cycle clears ovf_err.
- rst asserted mid-DATA -> all outputs 0 immediately (async); after release, no output until new markers.
